// File: rtl/payload_engine_ctrl_if.sv
// ---------------------------------------------------------------------------
// payload_engine_ctrl_if
// Bundles the per-packet controller's bus traffic:
//   s_*       byte stream from the payload extractor (valid/ready)
//   char_data registered byte to the character decoder
//   eng_*     shared engine controls (enable / clear) and sticky match vector
//   res_*     one result per packet to the downstream consumer (valid/ready)
// master : the surrounding core (byte source, engine bank, result sink)
// slave  : the controller itself
// ---------------------------------------------------------------------------
interface payload_engine_ctrl_if #(
   parameter int NUM_ENGINES = 16,
   parameter int LEN_W       = 11
);
   logic [7:0]             s_data;
   logic                   s_valid;
   logic                   s_last;
   logic                   s_ready;
   logic [7:0]             char_data;
   logic                   eng_en;
   logic                   eng_sod;
   logic [NUM_ENGINES-1:0] eng_match;
   logic                   res_valid;
   logic                   res_ready;
   logic [NUM_ENGINES-1:0] res_match;
   logic [LEN_W-1:0]       res_len;
   logic                   res_trunc;

   modport master (
      output s_data, s_valid, s_last, eng_match, res_ready,
      input  s_ready, char_data, eng_en, eng_sod,
             res_valid, res_match, res_len, res_trunc
   );

   modport slave (
      input  s_data, s_valid, s_last, eng_match, res_ready,
      output s_ready, char_data, eng_en, eng_sod,
             res_valid, res_match, res_len, res_trunc
   );
endinterface

// File: rtl/payload_engine_ctrl.sv
// ---------------------------------------------------------------------------
// payload_engine_ctrl
// Per-packet sequencer for a bank of regex payload engines. Takes a byte
// stream, releases the engine clear, feeds up to MAX_LEN bytes (registered
// char_data + eng_en), waits for the engine pipeline to drain, captures the
// sticky match vector and presents one result per packet.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         payload_engine_ctrl_if.slave (stream in, engine controls,
//               result out)
// ---------------------------------------------------------------------------
module payload_engine_ctrl #(
   parameter int NUM_ENGINES  = 16,
   parameter int MAX_LEN      = 1460,
   parameter int LEN_W        = 11,
   parameter int DRAIN_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   payload_engine_ctrl_if.slave bus
);

   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ARM, SCAN, DRAIN, REPORT} state_t;

   state_t                 state_q, state_d;
   logic [LEN_W-1:0]       cnt_q, cnt_d;
   logic                   trunc_q, trunc_d;
   logic [DRN_W-1:0]       drain_q, drain_d;
   logic [7:0]             char_q, char_d;
   logic                   en_q, en_d;
   logic [NUM_ENGINES-1:0] rmatch_q, rmatch_d;
   logic [LEN_W-1:0]       rlen_q, rlen_d;
   logic                   rtrunc_q, rtrunc_d;

   logic accept;
   assign accept = (state_q == SCAN) && bus.s_valid;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      trunc_d  = trunc_q;
      drain_d  = drain_q;
      char_d   = char_q;
      en_d     = 1'b0;
      rmatch_d = rmatch_q;
      rlen_d   = rlen_q;
      rtrunc_d = rtrunc_q;
      case (state_q)
         IDLE: begin
            if (bus.s_valid) state_d = ARM;
         end
         // Clear-release gap: engines leave reset one cycle before any enable.
         ARM: begin
            cnt_d   = '0;
            trunc_d = 1'b0;
            state_d = SCAN;
         end
         SCAN: begin
            if (accept) begin
               // Past MAX_LEN the byte is swallowed so the source can finish
               // the packet, but the engines never see it.
               if (cnt_q != LEN_W'(MAX_LEN)) begin
                  char_d = bus.s_data;
                  en_d   = 1'b1;
                  cnt_d  = cnt_q + LEN_W'(1);
               end else begin
                  trunc_d = 1'b1;
               end
               if (bus.s_last) begin
                  drain_d = '0;
                  state_d = DRAIN;
               end
            end
         end
         // First DRAIN cycle carries the final eng_en pulse; DRAIN_CYCLES
         // further cycles then let the match pipeline settle before capture.
         DRAIN: begin
            if (drain_q == DRN_W'(DRAIN_CYCLES)) begin
               rmatch_d = bus.eng_match;
               rlen_d   = cnt_q;
               rtrunc_d = trunc_q;
               state_d  = REPORT;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         REPORT: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         trunc_q  <= 1'b0;
         drain_q  <= '0;
         char_q   <= '0;
         en_q     <= 1'b0;
         rmatch_q <= '0;
         rlen_q   <= '0;
         rtrunc_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         trunc_q  <= trunc_d;
         drain_q  <= drain_d;
         char_q   <= char_d;
         en_q     <= en_d;
         rmatch_q <= rmatch_d;
         rlen_q   <= rlen_d;
         rtrunc_q <= rtrunc_d;
      end
   end

   // eng_en can only be high in SCAN/DRAIN, where the clear is released, so
   // clear and enable never overlap.
   assign bus.s_ready   = (state_q == SCAN);
   assign bus.eng_sod   = (state_q == IDLE) || (state_q == REPORT);
   assign bus.eng_en    = en_q;
   assign bus.char_data = char_q;
   assign bus.res_valid = (state_q == REPORT);
   assign bus.res_match = rmatch_q;
   assign bus.res_len   = rlen_q;
   assign bus.res_trunc = rtrunc_q;

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// ---------------------------------------------------------------------------
// tb_payload_engine_ctrl
// Random and directed packets against a packet-level reference model. The
// engine bank is modelled as 16 sticky detectors: engine i fires on any fed
// byte whose low nibble is i, cleared while eng_sod is high. Expected fed
// bytes and per-packet results are queued by the driver and popped by
// independent monitors.
// ---------------------------------------------------------------------------
module tb_payload_engine_ctrl;
   localparam int NE   = 16;
   localparam int MAXL = 8;
   localparam int LW   = 11;

   typedef struct {
      logic [NE-1:0] m;
      logic [LW-1:0] l;
      logic          t;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   payload_engine_ctrl_if #(.NUM_ENGINES(NE), .LEN_W(LW)) bus ();

   payload_engine_ctrl #(
      .NUM_ENGINES(NE), .MAX_LEN(MAXL), .LEN_W(LW), .DRAIN_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] exp_bytes[$];
   res_t       exp_res[$];
   logic [7:0] pkt[$];

   // packet-level model state
   int            m_cnt;
   logic [NE-1:0] m_match;
   logic          m_trunc;

   bit rr_hold = 1'b0;
   bit rr_rand = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // engine bank model: sticky, one-cycle registered
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.eng_match <= '0;
      else if (bus.eng_sod) bus.eng_match <= '0;
      else if (bus.eng_en) bus.eng_match <= bus.eng_match | (NE'(1) << bus.char_data[3:0]);
   end

   // result sink
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rr_hold) bus.res_ready = 1'b0;
         else if (rr_rand) bus.res_ready = ($urandom_range(0, 2) != 0);
         else bus.res_ready = 1'b1;
      end
   end

   // fed-byte monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.eng_en && bus.eng_sod) chk("sod_with_en", 32'(1), 32'(0));
         if (bus.eng_en) begin
            if (exp_bytes.size() == 0) chk("unexpected_eng_en", 32'(1), 32'(0));
            else chk("char_data", 32'(bus.char_data), 32'(exp_bytes.pop_front()));
         end
      end
   end

   // result monitor + hold-stability check
   logic          pv, pr, pt;
   logic [NE-1:0] pm;
   logic [LW-1:0] pl;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0; pr = 1'b0;
      end else begin
         if (bus.res_valid) chk("s_ready_in_report", 32'(bus.s_ready), 32'(0));
         if (pv && !pr) begin
            chk("hold_valid", 32'(bus.res_valid), 32'(1));
            chk("hold_match", 32'(bus.res_match), 32'(pm));
            chk("hold_len", 32'(bus.res_len), 32'(pl));
            chk("hold_trunc", 32'(bus.res_trunc), 32'(pt));
         end
         if (bus.res_valid && bus.res_ready) begin
            if (exp_res.size() == 0) chk("unexpected_result", 32'(1), 32'(0));
            else begin
               res_t e;
               e = exp_res.pop_front();
               chk("res_match", 32'(bus.res_match), 32'(e.m));
               chk("res_len", 32'(bus.res_len), 32'(e.l));
               chk("res_trunc", 32'(bus.res_trunc), 32'(e.t));
            end
         end
         pv = bus.res_valid; pr = bus.res_ready;
         pm = bus.res_match; pl = bus.res_len; pt = bus.res_trunc;
      end
   end

   task automatic model_clear();
      m_cnt = 0; m_match = '0; m_trunc = 1'b0;
   endtask

   // Drives one byte; returns at #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input bit last);
      bit ok;
      res_t r;
      ok = 1'b0;
      bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         if (bus.s_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) chk("s_ready_timeout", 32'(0), 32'(1));
      if (m_cnt < MAXL) begin
         exp_bytes.push_back(d);
         m_cnt++;
         m_match = m_match | (NE'(1) << d[3:0]);
      end else begin
         m_trunc = 1'b1;
      end
      if (last) begin
         r.m = m_match; r.l = LW'(m_cnt); r.t = m_trunc;
         exp_res.push_back(r);
         model_clear();
      end
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
   endtask

   // gmode: 0 none, 1 bytes 2 and 4 delayed 3 cycles, 2 random
   task automatic send_pkt(input int gmode);
      int g;
      for (int i = 0; i < pkt.size(); i++) begin
         g = 0;
         if (gmode == 1 && (i == 1 || i == 3)) g = 3;
         if (gmode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
         repeat (g) begin @(posedge clk); #1; end
         send_byte(pkt[i], i == pkt.size() - 1);
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 1000 && exp_res.size() != 0; k++) @(posedge clk);
      #1;
      chk("result_drained", 32'(exp_res.size()), 32'(0));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_eng_sod"}, 32'(bus.eng_sod), 32'(1));
      chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'(0));
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'(0));
      chk({tag, "_eng_en"}, 32'(bus.eng_en), 32'(0));
   endtask

   initial begin
      bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
      model_clear();
      // reset state
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst");
      chk("rst_char_data", 32'(bus.char_data), 32'(0));
      chk("rst_res_match", 32'(bus.res_match), 32'(0));
      chk("rst_res_len", 32'(bus.res_len), 32'(0));
      chk("rst_res_trunc", 32'(bus.res_trunc), 32'(0));
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("idle");

      // 5 bytes, match on engine 2
      pkt = '{8'h12, 8'h22, 8'h32, 8'h42, 8'h52};
      send_pkt(0); wait_drain();
      // same with gaps
      send_pkt(1); wait_drain();
      // 12 bytes with MAX_LEN 8 -> truncation
      pkt = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
              8'h8f, 8'h9e, 8'had, 8'hbc};
      send_pkt(0); wait_drain();
      // exactly MAX_LEN, then single byte
      pkt = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      send_pkt(0); wait_drain();
      pkt = '{8'hf9};
      send_pkt(0); wait_drain();

      // backpressure with second packet queued behind it
      rr_hold = 1'b1;
      pkt = '{8'h0a, 8'h1b, 8'h2c, 8'h3d};
      send_pkt(0);
      fork
         begin
            for (int k = 0; k < 100 && !bus.res_valid; k++) @(negedge clk);
            repeat (10) @(posedge clk);
            #1;
            rr_hold = 1'b0;
         end
         begin
            pkt = '{8'h05, 8'h16};
            send_pkt(0);
         end
      join
      wait_drain();

      // reset mid-SCAN after 3 bytes
      pkt = '{8'h31, 8'h42, 8'h53};
      for (int i = 0; i < 3; i++) send_byte(pkt[i], 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      exp_bytes.delete();
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pkt = '{8'h07, 8'h17, 8'h28};
      send_pkt(0); wait_drain();

      // random traffic
      rr_rand = 1'b1;
      for (int p = 0; p < 25; p++) begin
         int len;
         len = $urandom_range(1, 12);
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
         send_pkt(2);
      end
      wait_drain();
      repeat (5) @(posedge clk);
      #1;
      chk("bytes_drained", 32'(exp_bytes.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
